shared_alu: RTL and testbench

- Responder end of the ALU request/response interface used by the control loops (pid and future clients).
- Accepts one tagged arithmetic request per cycle (key, opcode, A, B) and returns the tagged result after a fixed pipeline latency.
- The key travels with the data so the client with that key latches the result. Key 0 means "no request / no result".
- Sits beside the PID block(s), driven by the same clock and global clr/en.

---
 rtl/shared_alu_pkg.sv | 17 +
 rtl/sat_trunc.sv | 16 +
 rtl/shared_alu.sv | 71 +++++++
 tb/tb_shared_alu.sv | 125 ++++++++++++
 4 files changed

// File: rtl/shared_alu_pkg.sv
// shared_alu_pkg: shared widths, opcodes and key constants for the ALU request/response interface.
//   KEY_SIZE    - width of the request/result tag
//   OPCODE_SIZE - width of the opcode field
//   PID_RES     - default operand/result width of the control loops
package shared_alu_pkg;
    localparam int KEY_SIZE    = 4;
    localparam int OPCODE_SIZE = 3;
    localparam int PID_RES     = 16;
    typedef logic [KEY_SIZE-1:0]    key_t;
    typedef logic [OPCODE_SIZE-1:0] op_t;
    localparam key_t KEY_NONE = '0;
    localparam op_t  OP_NOP   = 3'd0;
    localparam op_t  OP_ADD   = 3'd1;
    localparam op_t  OP_SUB   = 3'd2;
    localparam op_t  OP_MUL   = 3'd3;
    localparam op_t  OP_NEG   = 3'd4;
endpackage

// File: rtl/sat_trunc.sv
// sat_trunc: combinational signed clamp from iw bits down to ow bits.
//   din  - signed input, iw bits
//   dout - din clamped to [-2^(ow-1), 2^(ow-1)-1], ow bits
module sat_trunc #(
    parameter int iw = 32,
    parameter int ow = 16
) (
    input  logic signed [iw-1:0] din,
    output logic signed [ow-1:0] dout
);
    // The value fits when every bit from the output sign bit upward is a copy of the sign.
    logic fits;
    assign fits = (&din[iw-1:ow-1]) | ~(|din[iw-1:ow-1]);
    always_comb
        dout = fits ? din[ow-1:0] : din[iw-1] ? {1'b1, {(ow-1){1'b0}}} : {1'b0, {(ow-1){1'b1}}};
endmodule

// File: rtl/shared_alu.sv
// shared_alu: tagged 3-stage ADD/SUB/MUL/NEG pipeline with saturated fixed-point results.
//   clk, rst (sync, active-low), clr (sync flush), en (advance)
//   alu_key_i/alu_op_i/alu_A_i/alu_B_i - request; key 0 = idle
//   alu_key_o/alu_O_o                  - tagged result; key 0 = no result
module shared_alu
    import shared_alu_pkg::*;
#(
    parameter int nbits = PID_RES,
    parameter int frac  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [KEY_SIZE-1:0]     alu_key_i,
    input  logic [OPCODE_SIZE-1:0]  alu_op_i,
    input  logic signed [nbits-1:0] alu_A_i,
    input  logic signed [nbits-1:0] alu_B_i,
    output logic [KEY_SIZE-1:0]     alu_key_o,
    output logic signed [nbits-1:0] alu_O_o
);
    localparam int ww = 2 * nbits;
    key_t                    key1, key2;
    op_t                     op1;
    logic signed [nbits-1:0] a1, b1;
    logic                    mul2;
    logic signed [ww-1:0]    aw, bw, sum, diff, prod, neg, raw_next, raw2, scaled;
    logic signed [nbits-1:0] sat;
    // All arithmetic is done at double width; the product of two sign-extended
    // nbits values is exact in its low 2*nbits bits.
    assign aw   = {{nbits{a1[nbits-1]}}, a1};
    assign bw   = {{nbits{b1[nbits-1]}}, b1};
    assign sum  = aw + bw;
    assign diff = aw - bw;
    assign prod = aw * bw;
    assign neg  = -aw;
    always_comb
        raw_next = op1 == OP_ADD ? sum  :
                   op1 == OP_SUB ? diff :
                   op1 == OP_MUL ? prod :
                   op1 == OP_NEG ? neg  : '0;
    always_comb
        scaled = mul2 ? raw2 >>> frac : raw2;
    sat_trunc #(.iw(ww), .ow(nbits)) u_sat (
        .din  (scaled),
        .dout (sat)
    );
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            key1      <= KEY_NONE;
            op1       <= OP_NOP;
            a1        <= '0;
            b1        <= '0;
            key2      <= KEY_NONE;
            mul2      <= 1'b0;
            raw2      <= '0;
            alu_key_o <= KEY_NONE;
            alu_O_o   <= '0;
        end else if (en) begin
            key1      <= alu_key_i;
            op1       <= alu_op_i;
            a1        <= alu_A_i;
            b1        <= alu_B_i;
            key2      <= key1;
            mul2      <= op1 == OP_MUL;
            raw2      <= key1 == KEY_NONE ? '0 : raw_next;
            alu_key_o <= key2;
            alu_O_o   <= key2 == KEY_NONE ? '0 : sat;
        end
    end
endmodule

// File: tb/tb_shared_alu.sv
// tb_shared_alu: directed self-checking bench for shared_alu (nbits=16, frac=8).
module tb_shared_alu;
    import shared_alu_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        en  = 1'b1;
    logic [3:0]  key = '0;
    logic [2:0]  op  = '0;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic [3:0]  key_o;
    logic [15:0] o;
    int tests = 0;
    int fails = 0;
    shared_alu #(.nbits(16), .frac(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (en),
        .alu_key_i (key),
        .alu_op_i  (op),
        .alu_A_i   (a),
        .alu_B_i   (b),
        .alu_key_o (key_o),
        .alu_O_o   (o)
    );
    always #5 clk = ~clk;
    task automatic cyc(input logic [3:0] k, input logic [2:0] p, input logic [15:0] x, input logic [15:0] y);
        key = k;
        op  = p;
        a   = x;
        b   = y;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [3:0] ek, input logic [15:0] eo);
        tests++;
        assert (key_o === ek && o === eo) else begin
            fails++;
            $error("FAIL %s: got key=%0d O=%h, expected key=%0d O=%h", tag, key_o, o, ek, eo);
        end
    endtask
    initial begin
        rst = 1'b0;
        repeat (3) begin
            cyc(4'd0, OP_NOP, 16'h0, 16'h0);
            chk("reset", 4'd0, 16'h0000);
        end
        rst = 1'b1;
        repeat (3) begin
            cyc(4'd0, OP_ADD, 16'h0005, 16'h0005);
            chk("idle_bubble", 4'd0, 16'h0000);
        end
        cyc(4'd1, OP_ADD, 16'h0100, 16'h0200);
        cyc(4'd2, OP_SUB, 16'h0100, 16'h0300);
        cyc(4'd3, OP_MUL, 16'h0180, 16'h0200);
        chk("stream_add", 4'd1, 16'h0300);
        cyc(4'd4, OP_NEG, 16'h0005, 16'h0000);
        chk("stream_sub", 4'd2, 16'hFE00);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("stream_mul", 4'd3, 16'h0300);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("stream_neg", 4'd4, 16'hFFFB);
        cyc(4'd1, OP_ADD, 16'h7000, 16'h2000);
        cyc(4'd2, OP_SUB, 16'h8000, 16'h0001);
        cyc(4'd3, OP_MUL, 16'h4000, 16'h4000);
        chk("sat_add", 4'd1, 16'h7FFF);
        cyc(4'd4, OP_NEG, 16'h8000, 16'h0000);
        chk("sat_sub", 4'd2, 16'h8000);
        cyc(4'd5, OP_MUL, 16'hFF80, 16'h0080);
        chk("sat_mul", 4'd3, 16'h7FFF);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("sat_neg", 4'd4, 16'h7FFF);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("mul_neg_frac", 4'd5, 16'hFFC0);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("drain", 4'd0, 16'h0000);
        cyc(4'd8, OP_ADD, 16'h0003, 16'h0004);
        cyc(4'd5, OP_ADD, 16'h0001, 16'h0001);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("pre_stall", 4'd8, 16'h0007);
        en = 1'b0;
        repeat (4) begin
            cyc(4'd10, OP_ADD, 16'h0009, 16'h0009);
            chk("stall_hold", 4'd8, 16'h0007);
        end
        en = 1'b1;
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("stall_result", 4'd5, 16'h0002);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("stall_ignored_input", 4'd0, 16'h0000);
        cyc(4'd1, OP_ADD, 16'h0001, 16'h0001);
        cyc(4'd2, OP_ADD, 16'h0002, 16'h0002);
        chk("pre_flush", 4'd0, 16'h0000);
        clr = 1'b1;
        cyc(4'd6, OP_ADD, 16'h0003, 16'h0003);
        clr = 1'b0;
        chk("flush", 4'd0, 16'h0000);
        repeat (3) begin
            cyc(4'd0, OP_NOP, 16'h0, 16'h0);
            chk("post_flush", 4'd0, 16'h0000);
        end
        cyc(4'd1, OP_ADD, 16'h0001, 16'h0001);
        cyc(4'd2, OP_ADD, 16'h0002, 16'h0002);
        cyc(4'd3, OP_ADD, 16'h0003, 16'h0003);
        chk("pre_reset", 4'd1, 16'h0002);
        rst = 1'b0;
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("mid_reset", 4'd0, 16'h0000);
        rst = 1'b1;
        repeat (2) begin
            cyc(4'd0, OP_NOP, 16'h0, 16'h0);
            chk("post_reset", 4'd0, 16'h0000);
        end
        cyc(4'd9, 3'd7, 16'h0005, 16'h0005);
        cyc(4'd7, OP_NOP, 16'h0003, 16'h0003);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("undef_op", 4'd9, 16'h0000);
        cyc(4'd0, OP_NOP, 16'h0, 16'h0);
        chk("nop_op", 4'd7, 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
